// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } ifu_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] IFU_PC_STEP = 32'd4;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer of fetch_entry_t; flush empties it and wins over push/pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output fetch_entry_t               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          full;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, cache lookup, miss stall, prefetch FIFO to decode.
// Optional performance counters enabled by macro IFU_PERF_CNT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MISS_PENALTY = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_data,
  input  logic        ic_hit,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt_total
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]  pc_q, pc_d;
  logic         req_valid_q, req_valid_d;
  logic [31:0]  req_pc_q, req_pc_d;
  ifu_state_t   state_q, state_d;
  logic [3:0]   miss_cnt_q, miss_cnt_d;
  logic [31:0]  miss_data_q, miss_data_d;

  logic         push, pop, flush;
  fetch_entry_t push_entry, head;
  logic [CW-1:0] fifo_count, inflight;
  logic         fifo_empty, credit_ok;

  // The outstanding lookup counts against FIFO space so a push never finds it full.
  assign inflight  = fifo_count + CW'(req_valid_q);
  assign credit_ok = (inflight < CW'(FIFO_DEPTH));

  always_comb begin
    pc_d        = pc_q;
    req_valid_d = 1'b0;
    req_pc_d    = req_pc_q;
    state_d     = state_q;
    miss_cnt_d  = miss_cnt_q;
    miss_data_d = miss_data_q;
    push        = 1'b0;
    push_entry  = '{pc: req_pc_q, instr: ic_data};
    case (state_q)
      RUN: begin
        if (req_valid_q && !ic_hit) begin
          miss_data_d = ic_data;
          miss_cnt_d  = 4'(MISS_PENALTY - 1);
          pc_d        = req_pc_q + IFU_PC_STEP;
          state_d     = MISS;
        end else begin
          push = req_valid_q;
          if (credit_ok) begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + IFU_PC_STEP;
          end
        end
      end
      MISS: begin
        miss_cnt_d = miss_cnt_q - 4'd1;
        if (miss_cnt_q == 4'd0) begin
          push             = 1'b1;
          push_entry.instr = miss_data_q;
          miss_cnt_d       = 4'd0;
          state_d          = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      req_valid_d = 1'b0;
      state_d     = RUN;
      miss_cnt_d  = 4'd0;
      push        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      state_q     <= RUN;
      miss_cnt_q  <= 4'd0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      state_q     <= state_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q    <= req_pc_d;
    miss_data_q <= miss_data_d;
  end

  assign flush = redirect_valid;
  assign pop   = id_valid && id_ready && !redirect_valid;

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign ic_addr  = pc_q;
  assign id_valid = !fifo_empty;
  assign id_instr = id_valid ? head.instr : 32'h0;
  assign id_pc    = id_valid ? head.pc    : 32'h0;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_tot_q;

  // Squashed responses still count: the cache did the lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'h0;
      miss_tot_q <= 32'h0;
    end else if (state_q == RUN && req_valid_q) begin
      if (ic_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else        miss_tot_q <= miss_tot_q + 32'd1;
    end
  end

  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt_total = miss_tot_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered always-answering cache stub.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] ic_addr;
  logic [31:0] ic_data;
  logic        ic_hit;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt_total;
`endif

  logic [31:0] miss_a, miss_b;
  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] HIT_KEY  = 32'hC0DE_0000;
  localparam logic [31:0] MISS_KEY = 32'hBEEF_0000;

  instr_fetch_unit #(
    .RESET_PC     (32'h0000_0040),
    .MISS_PENALTY (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_addr        (ic_addr),
    .ic_data        (ic_data),
    .ic_hit         (ic_hit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt_total (miss_cnt_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache stub: hit word = addr ^ HIT_KEY, refill word on a miss = addr ^ MISS_KEY.
  always @(posedge clk) begin
    if (ic_addr == miss_a || ic_addr == miss_b) begin
      ic_hit  <= 1'b0;
      ic_data <= ic_addr ^ MISS_KEY;
    end else begin
      ic_hit  <= 1'b1;
      ic_data <= ic_addr ^ HIT_KEY;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 0: first cycle with reset released.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    miss_a = 32'h1; miss_b = 32'h1;

    // Hit stream from RESET_PC
    do_reset();
    check("rst_addr",  ic_addr,  32'h40);
    check("rst_vld",   {31'h0, id_valid}, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc",    id_pc,    32'h0);
    step();
    check("hit_c1_addr", ic_addr, 32'h44);
    check("hit_c1_vld",  {31'h0, id_valid}, 32'h0);
    step();
    check("hit_c2_addr",  ic_addr, 32'h48);
    check("hit_c2_vld",   {31'h0, id_valid}, 32'h1);
    check("hit_c2_pc",    id_pc,   32'h40);
    check("hit_c2_instr", id_instr, 32'h40 ^ HIT_KEY);
    step();
    check("hit_c3_pc", id_pc, 32'h44);
    step();
    check("hit_c4_pc", id_pc, 32'h48);

    // Miss at 0x44, penalty 4: issued c1, delivered c7
    miss_a = 32'h44;
    do_reset();
    step(); step();
    check("miss_c2_pc", id_pc, 32'h40);
    repeat (4) step();
    check("miss_c6_vld", {31'h0, id_valid}, 32'h0);
    step();
    check("miss_c7_vld",   {31'h0, id_valid}, 32'h1);
    check("miss_c7_pc",    id_pc,    32'h44);
    check("miss_c7_instr", id_instr, 32'h44 ^ MISS_KEY);
    check("miss_c7_addr",  ic_addr,  32'h48);
    step();
    check("miss_c8_vld", {31'h0, id_valid}, 32'h0);
    step();
    check("miss_c9_pc",    id_pc,    32'h48);
    check("miss_c9_instr", id_instr, 32'h48 ^ HIT_KEY);

    // Decode stalled: four entries then pc freezes, drain in order
    miss_a = 32'h1; id_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("stall_c1_addr", ic_addr, 32'h0);
    repeat (5) step();
    check("stall_c6_addr", ic_addr, 32'h10);
    repeat (5) step();
    check("stall_c11_addr", ic_addr, 32'h10);
    check("stall_c11_vld",  {31'h0, id_valid}, 32'h1);
    check("stall_c11_pc",   id_pc, 32'h0);
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("drain_%0d_pc", i), id_pc, 32'(i * 4));
    end

    // Redirect during MISS with three entries queued
    miss_a = 32'h4C; id_ready = 1'b0;
    do_reset();
    repeat (5) step();
    check("rdr_c5_vld", {31'h0, id_valid}, 32'h1);
    check("rdr_c5_pc",  id_pc, 32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0; id_ready = 1'b1;
    check("rdr_c6_vld",  {31'h0, id_valid}, 32'h0);
    check("rdr_c6_addr", ic_addr, 32'h100);
    step();
    check("rdr_c7_vld", {31'h0, id_valid}, 32'h0);
    step();
    check("rdr_c8_pc",    id_pc,    32'h100);
    check("rdr_c8_instr", id_instr, 32'h100 ^ HIT_KEY);
    step();
    check("rdr_c9_pc", id_pc, 32'h104);

    // Reset for one cycle in the middle of a miss
    miss_a = 32'h44; id_ready = 1'b1;
    do_reset();
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check("mrst_addr",  ic_addr,  32'h40);
    check("mrst_vld",   {31'h0, id_valid}, 32'h0);
    check("mrst_instr", id_instr, 32'h0);
    check("mrst_pc",    id_pc,    32'h0);
    rst_n = 1'b1; miss_a = 32'h1;
    step();
    check("mrst_c1_addr", ic_addr, 32'h44);
    step();
    check("mrst_c2_pc", id_pc, 32'h40);
    step();
    check("mrst_c3_pc",    id_pc,    32'h44);
    check("mrst_c3_instr", id_instr, 32'h44 ^ HIT_KEY);

    // Two misses then a redirect refill: 6 hits, 2 misses in total
    miss_a = 32'h44; miss_b = 32'h48; id_ready = 1'b0;
    do_reset();
    repeat (25) step();
    check("perf_frz_addr", ic_addr, 32'h50);
    check("perf_frz_pc",   id_pc,   32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    check("perf_end_addr", ic_addr, 32'h210);
    check("perf_end_pc",   id_pc,   32'h200);
`ifdef IFU_PERF_CNT_EN
    check("perf_hits",   hit_cnt,        32'd6);
    check("perf_misses", miss_cnt_total, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
